// File: rtl/rdma_sq_tracker.sv
// Send-queue tracker: registers SQ commands toward the RDMA stack and matches
// returning acks against issued tags in order, with counters and sticky errors.
module rdma_sq_tracker #(
  parameter int unsigned SQ_BITS  = 512,
  parameter int unsigned ACK_BITS = 32,
  parameter int unsigned TAG_BITS = 10,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_sq_valid,
  output logic                     s_sq_ready,
  input  logic [SQ_BITS-1:0]       s_sq_data,
  output logic                     m_sq_valid,
  input  logic                     m_sq_ready,
  output logic [SQ_BITS-1:0]       m_sq_data,
  input  logic                     s_ack_valid,
  output logic                     s_ack_ready,
  input  logic [ACK_BITS-1:0]      s_ack_data,
  input  logic                     clr,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic [31:0]              ack_cnt,
  output logic [31:0]              nack_cnt,
  output logic                     err_mismatch,
  output logic                     err_unexpected
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  logic [TAG_BITS-1:0] tag_mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  logic                push;
  logic                pop;
  logic                unexp;
  logic                mismatch;
  logic                have_out;
  logic [TAG_BITS-1:0] ack_tag;
  logic                ack_nack;
  logic                unused_ack_bits;

  assign ack_tag         = s_ack_data[TAG_BITS-1:0];
  assign ack_nack        = s_ack_data[TAG_BITS];
  assign unused_ack_bits = ^s_ack_data[ACK_BITS-1:TAG_BITS+1];

  // Acks are always sunk; anything arriving during reset hits held flops and is lost.
  assign s_ack_ready = 1'b1;

  assign have_out = (outstanding != '0);
  assign s_sq_ready = aresetn && (!m_sq_valid || m_sq_ready) && (outstanding < OW'(DEPTH));
  assign push     = s_sq_valid && s_sq_ready;
  assign pop      = s_ack_valid && have_out;
  assign unexp    = s_ack_valid && !have_out;
  assign mismatch = pop && (tag_mem[rd_ptr] != ack_tag);

  // Single output register on the SQ path
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_sq_valid <= 1'b0;
      m_sq_data  <= '0;
    end else if (push) begin
      m_sq_valid <= 1'b1;
      m_sq_data  <= s_sq_data;
    end else if (m_sq_ready) begin
      m_sq_valid <= 1'b0;
    end
  end

  // Tag storage needs no reset: pointers alone define its contents
  always_ff @(posedge aclk) begin
    if (push) tag_mem[wr_ptr] <= s_sq_data[TAG_BITS-1:0];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Counters and sticky flags; clr wins over any coincident event
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ack_cnt        <= '0;
      nack_cnt       <= '0;
      err_mismatch   <= 1'b0;
      err_unexpected <= 1'b0;
    end else if (clr) begin
      ack_cnt        <= '0;
      nack_cnt       <= '0;
      err_mismatch   <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      if (pop && ack_nack)  nack_cnt <= nack_cnt + 32'd1;
      if (pop && !ack_nack) ack_cnt  <= ack_cnt + 32'd1;
      if (mismatch)         err_mismatch   <= 1'b1;
      if (unexp)            err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rdma_sq_tracker.sv
// Randomized self-checking bench for rdma_sq_tracker against a queue-based model.
module tb_rdma_sq_tracker;

  localparam int unsigned SQ_BITS  = 512;
  localparam int unsigned ACK_BITS = 32;
  localparam int unsigned TAG_BITS = 10;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned OW       = $clog2(DEPTH) + 1;

  logic                 aclk = 1'b0;
  logic                 aresetn;
  logic                 s_sq_valid;
  logic                 s_sq_ready;
  logic [SQ_BITS-1:0]   s_sq_data;
  logic                 m_sq_valid;
  logic                 m_sq_ready;
  logic [SQ_BITS-1:0]   m_sq_data;
  logic                 s_ack_valid;
  logic                 s_ack_ready;
  logic [ACK_BITS-1:0]  s_ack_data;
  logic                 clr;
  logic [OW-1:0]        outstanding;
  logic [31:0]          ack_cnt;
  logic [31:0]          nack_cnt;
  logic                 err_mismatch;
  logic                 err_unexpected;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: tags in flight, downstream register contents, counters, flags
  logic [TAG_BITS-1:0]  q_tag [$];
  logic [SQ_BITS-1:0]   dq [$];
  logic [31:0]          m_ack;
  logic [31:0]          m_nack;
  bit                   m_errm;
  bit                   m_erru;

  rdma_sq_tracker #(
    .SQ_BITS(SQ_BITS), .ACK_BITS(ACK_BITS), .TAG_BITS(TAG_BITS), .DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_sq_valid(s_sq_valid), .s_sq_ready(s_sq_ready), .s_sq_data(s_sq_data),
    .m_sq_valid(m_sq_valid), .m_sq_ready(m_sq_ready), .m_sq_data(m_sq_data),
    .s_ack_valid(s_ack_valid), .s_ack_ready(s_ack_ready), .s_ack_data(s_ack_data),
    .clr(clr), .outstanding(outstanding), .ack_cnt(ack_cnt), .nack_cnt(nack_cnt),
    .err_mismatch(err_mismatch), .err_unexpected(err_unexpected)
  );

  always #5 aclk = ~aclk;

  function automatic void model_reset();
    q_tag.delete();
    dq.delete();
    m_ack  = '0;
    m_nack = '0;
    m_errm = 1'b0;
    m_erru = 1'b0;
  endfunction

  function automatic bit exp_ready();
    return (dq.size() == 0 || m_sq_ready) && (q_tag.size() < DEPTH);
  endfunction

  function automatic logic [ACK_BITS-1:0] ackw(input logic [TAG_BITS-1:0] t, input bit nack);
    return ACK_BITS'({nack, t});
  endfunction

  function automatic logic [SQ_BITS-1:0] rnd_cmd(input logic [TAG_BITS-1:0] t);
    logic [SQ_BITS-1:0] r;
    for (int i = 0; i < SQ_BITS / 32; i++) r[i*32 +: 32] = $urandom;
    r[TAG_BITS-1:0] = t;
    return r;
  endfunction

  task automatic drive(input bit sv, input logic [SQ_BITS-1:0] sd, input bit mr,
                       input bit av, input logic [ACK_BITS-1:0] ad, input bit c);
    s_sq_valid  = sv;
    s_sq_data   = sd;
    m_sq_ready  = mr;
    s_ack_valid = av;
    s_ack_data  = ad;
    clr         = c;
  endtask

  // Advance one clock, applying the protocol rules to the model from the driven inputs
  task automatic step();
    bit rdy;
    bit ok;
    bit bad;
    bit mm;
    logic [TAG_BITS-1:0] head;
    rdy = exp_ready();
    ok = 0; bad = 0; mm = 0;
    if (dq.size() != 0 && m_sq_ready) void'(dq.pop_front());
    if (s_ack_valid) begin
      if (q_tag.size() > 0) begin
        head = q_tag.pop_front();
        ok = 1;
        mm = (head != s_ack_data[TAG_BITS-1:0]);
      end else begin
        bad = 1;
      end
    end
    if (s_sq_valid && rdy) begin
      dq.push_back(s_sq_data);
      q_tag.push_back(s_sq_data[TAG_BITS-1:0]);
    end
    if (clr) begin
      m_ack = '0; m_nack = '0; m_errm = 0; m_erru = 0;
    end else begin
      if (ok && s_ack_data[TAG_BITS])  m_nack = m_nack + 32'd1;
      if (ok && !s_ack_data[TAG_BITS]) m_ack  = m_ack + 32'd1;
      if (mm)  m_errm = 1;
      if (bad) m_erru = 1;
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    drive(0, '0, 1, 0, '0, 0);
  endtask

  task automatic test_reset();
    n_cmp++; if (s_sq_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_sq_ready: got %b exp 0", s_sq_ready); end
    n_cmp++; if (m_sq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_sq_valid: got %b exp 0", m_sq_valid); end
    n_cmp++; if (outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding: got %0d exp 0", outstanding); end
    n_cmp++; if (ack_cnt !== 32'd0 || nack_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d exp 0/0", ack_cnt, nack_cnt); end
    n_cmp++; if (s_ack_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ack_ready: got %b exp 1", s_ack_ready); end
    aresetn = 1'b1;
    #1;
    n_cmp++; if (s_sq_ready !== 1'b1) begin n_fail++; $display("FAIL release_s_sq_ready: got %b exp 1", s_sq_ready); end
  endtask

  task automatic test_basic();
    logic [SQ_BITS-1:0] cmd;
    for (int t = 1; t <= 3; t++) begin
      cmd = rnd_cmd(TAG_BITS'(t));
      drive(1, cmd, 1, 0, '0, 0);
      step();
      n_cmp++; if (m_sq_valid !== 1'b1 || m_sq_data !== cmd) begin n_fail++; $display("FAIL basic_m_sq tag%0d: got v=%b d=%h exp v=1 d=%h", t, m_sq_valid, m_sq_data, cmd); end
    end
    idle(); step();
    n_cmp++; if (outstanding !== OW'(3)) begin n_fail++; $display("FAIL basic_outstanding3: got %0d exp 3", outstanding); end
    for (int t = 1; t <= 3; t++) begin
      drive(0, '0, 1, 1, ackw(TAG_BITS'(t), 0), 0);
      step();
    end
    idle();
    n_cmp++; if (outstanding !== '0) begin n_fail++; $display("FAIL basic_outstanding0: got %0d exp 0", outstanding); end
    n_cmp++; if (ack_cnt !== 32'd3) begin n_fail++; $display("FAIL basic_ack_cnt: got %0d exp 3", ack_cnt); end
    n_cmp++; if (err_mismatch !== 1'b0 || err_unexpected !== 1'b0) begin n_fail++; $display("FAIL basic_errors: got %b%b exp 00", err_mismatch, err_unexpected); end
  endtask

  task automatic test_full();
    int acc = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      drive(1, rnd_cmd(TAG_BITS'(100 + i)), 1, 0, '0, 0);
      #1;
      if (s_sq_valid && s_sq_ready) acc++;
      step();
    end
    n_cmp++; if (acc != DEPTH) begin n_fail++; $display("FAIL full_accepted: got %0d exp %0d", acc, DEPTH); end
    n_cmp++; if (outstanding !== OW'(DEPTH)) begin n_fail++; $display("FAIL full_outstanding: got %0d exp %0d", outstanding, DEPTH); end
    n_cmp++; if (s_sq_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b exp 0", s_sq_ready); end
    drive(1, rnd_cmd(TAG_BITS'(200)), 1, 1, ackw(q_tag[0], 0), 0);
    #1;
    n_cmp++; if (s_sq_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_with_ack: got %b exp 0", s_sq_ready); end
    step();
    drive(1, rnd_cmd(TAG_BITS'(201)), 1, 0, '0, 0);
    #1;
    n_cmp++; if (s_sq_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_reassert: got %b exp 1", s_sq_ready); end
    step();
    n_cmp++; if (outstanding !== OW'(DEPTH)) begin n_fail++; $display("FAIL full_outstanding_stay: got %0d exp %0d", outstanding, DEPTH); end
    for (int i = 0; i < DEPTH + 2 && q_tag.size() > 0; i++) begin
      drive(0, '0, 1, 1, ackw(q_tag[0], 0), 0);
      step();
    end
    idle();
    n_cmp++; if (outstanding !== '0 || err_mismatch !== 1'b0) begin n_fail++; $display("FAIL full_drain: got out=%0d mm=%b exp 0/0", outstanding, err_mismatch); end
  endtask

  task automatic test_backpressure();
    logic [SQ_BITS-1:0] cmd0;
    cmd0 = rnd_cmd(TAG_BITS'(7));
    drive(1, cmd0, 0, 0, '0, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1, rnd_cmd(TAG_BITS'(300 + i)), 0, 0, '0, 0);
      #1;
      n_cmp++; if (m_sq_valid !== 1'b1 || m_sq_data !== cmd0) begin n_fail++; $display("FAIL bp_hold cyc%0d: got v=%b d=%h exp v=1 d=%h", i, m_sq_valid, m_sq_data, cmd0); end
      n_cmp++; if (s_sq_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc%0d: got %b exp 0", i, s_sq_ready); end
      step();
    end
    n_cmp++; if (outstanding !== OW'(1)) begin n_fail++; $display("FAIL bp_outstanding: got %0d exp 1", outstanding); end
    idle(); step();
    n_cmp++; if (m_sq_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b exp 0", m_sq_valid); end
    drive(0, '0, 1, 1, ackw(TAG_BITS'(7), 0), 0);
    step();
    idle();
  endtask

  task automatic test_errors();
    drive(0, '0, 1, 0, '0, 1); step();
    drive(1, rnd_cmd(TAG_BITS'(5)), 1, 0, '0, 0); step();
    idle(); step();
    drive(0, '0, 1, 1, ackw(TAG_BITS'(6), 1), 0); step();
    idle();
    n_cmp++; if (err_mismatch !== 1'b1) begin n_fail++; $display("FAIL err_mismatch: got %b exp 1", err_mismatch); end
    n_cmp++; if (nack_cnt !== 32'd1) begin n_fail++; $display("FAIL err_nack_cnt: got %0d exp 1", nack_cnt); end
    n_cmp++; if (outstanding !== '0) begin n_fail++; $display("FAIL err_outstanding: got %0d exp 0", outstanding); end
    drive(0, '0, 1, 1, ackw(TAG_BITS'(8), 1), 0); step();
    idle();
    n_cmp++; if (err_unexpected !== 1'b1) begin n_fail++; $display("FAIL err_unexpected: got %b exp 1", err_unexpected); end
    n_cmp++; if (nack_cnt !== 32'd1 || ack_cnt !== 32'd0 || outstanding !== '0) begin n_fail++; $display("FAIL err_unexp_side: got n=%0d a=%0d o=%0d exp 1/0/0", nack_cnt, ack_cnt, outstanding); end
    drive(0, '0, 1, 0, '0, 1); step();
    idle();
    n_cmp++; if ({err_mismatch, err_unexpected} !== 2'b00 || nack_cnt !== 32'd0 || ack_cnt !== 32'd0) begin n_fail++; $display("FAIL err_clr: got flags=%b%b n=%0d a=%0d exp 00/0/0", err_mismatch, err_unexpected, nack_cnt, ack_cnt); end
  endtask

  task automatic test_async_reset();
    logic [SQ_BITS-1:0] cmd9;
    for (int i = 0; i < 5; i++) begin
      drive(1, rnd_cmd(TAG_BITS'(400 + i)), 1, 0, '0, 0); step();
    end
    drive(0, '0, 0, 1, ackw(q_tag[0], 0), 0); step();
    drive(0, '0, 0, 0, '0, 0);
    n_cmp++; if (outstanding !== OW'(4) || m_sq_valid !== 1'b1) begin n_fail++; $display("FAIL ar_setup: got o=%0d v=%b exp 4/1", outstanding, m_sq_valid); end
    #3;
    aresetn = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (m_sq_valid !== 1'b0 || s_sq_ready !== 1'b0) begin n_fail++; $display("FAIL ar_handshake: got v=%b r=%b exp 0/0", m_sq_valid, s_sq_ready); end
    n_cmp++; if (outstanding !== '0 || ack_cnt !== 32'd0) begin n_fail++; $display("FAIL ar_state: got o=%0d a=%0d exp 0/0", outstanding, ack_cnt); end
    s_ack_valid = 1'b1;
    s_ack_data  = ackw(TAG_BITS'(401), 0);
    repeat (2) @(posedge aclk);
    #1;
    n_cmp++; if (s_ack_ready !== 1'b1 || ack_cnt !== 32'd0 || err_unexpected !== 1'b0) begin n_fail++; $display("FAIL ar_ack_in_reset: got rdy=%b a=%0d u=%b exp 1/0/0", s_ack_ready, ack_cnt, err_unexpected); end
    idle();
    aresetn = 1'b1;
    #1;
    n_cmp++; if (s_sq_ready !== 1'b1) begin n_fail++; $display("FAIL ar_release_ready: got %b exp 1", s_sq_ready); end
    cmd9 = rnd_cmd(TAG_BITS'(9));
    drive(1, cmd9, 1, 0, '0, 0); step();
    n_cmp++; if (m_sq_data !== cmd9 || outstanding !== OW'(1)) begin n_fail++; $display("FAIL ar_issue9: got o=%0d d=%h exp 1 d=%h", outstanding, m_sq_data, cmd9); end
    drive(0, '0, 1, 1, ackw(TAG_BITS'(9), 0), 0); step();
    idle();
    n_cmp++; if (outstanding !== '0 || ack_cnt !== 32'd1 || err_mismatch !== 1'b0 || err_unexpected !== 1'b0) begin n_fail++; $display("FAIL ar_ack9: got o=%0d a=%0d mm=%b u=%b exp 0/1/0/0", outstanding, ack_cnt, err_mismatch, err_unexpected); end
  endtask

  task automatic test_random();
    bit sv, mr, av, c;
    logic [TAG_BITS-1:0] t;
    for (int cyc = 0; cyc < 800; cyc++) begin
      sv = ($urandom_range(0, 2) != 0);
      mr = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 49) == 0);
      if (q_tag.size() > 0) begin
        av = ($urandom_range(0, 9) < 4);
        t  = ($urandom_range(0, 9) == 0) ? TAG_BITS'($urandom) : q_tag[0];
      end else begin
        av = ($urandom_range(0, 29) == 0);
        t  = TAG_BITS'($urandom);
      end
      drive(sv, rnd_cmd(TAG_BITS'($urandom)), mr, av, ackw(t, bit'($urandom_range(0, 1))), c);
      #1;
      n_cmp++; if (s_sq_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready cyc%0d: got %b exp %b", cyc, s_sq_ready, exp_ready()); end
      n_cmp++; if (m_sq_valid !== (dq.size() != 0)) begin n_fail++; $display("FAIL rnd_m_valid cyc%0d: got %b exp %b", cyc, m_sq_valid, dq.size() != 0); end
      if (dq.size() != 0) begin
        n_cmp++; if (m_sq_data !== dq[0]) begin n_fail++; $display("FAIL rnd_m_data cyc%0d: got %h exp %h", cyc, m_sq_data, dq[0]); end
      end
      n_cmp++; if (outstanding !== OW'(q_tag.size())) begin n_fail++; $display("FAIL rnd_outstanding cyc%0d: got %0d exp %0d", cyc, outstanding, q_tag.size()); end
      n_cmp++; if (ack_cnt !== m_ack || nack_cnt !== m_nack) begin n_fail++; $display("FAIL rnd_counters cyc%0d: got %0d/%0d exp %0d/%0d", cyc, ack_cnt, nack_cnt, m_ack, m_nack); end
      n_cmp++; if (err_mismatch !== m_errm || err_unexpected !== m_erru) begin n_fail++; $display("FAIL rnd_flags cyc%0d: got %b%b exp %b%b", cyc, err_mismatch, err_unexpected, m_errm, m_erru); end
      n_cmp++; if (s_ack_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ack_ready cyc%0d: got %b exp 1", cyc, s_ack_ready); end
      step();
    end
    idle();
  endtask

  initial begin
    aresetn = 1'b0;
    model_reset();
    drive(0, '0, 0, 0, '0, 0);
    repeat (3) @(posedge aclk);
    #1;
    test_reset();
    test_basic();
    test_full();
    test_backpressure();
    test_errors();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
